hex_display_arbiter: RTL and testbench

- Shares the board's single 8-digit hex display among NREQ result producers (e.g. ALU, multiplier, load unit).
- Each producer raises a request carrying a 16-bit result and two 8-bit operand tags.
- Round-robin arbitration picks one requester, acknowledges it, and holds its value on the display for a programmable dwell time before serving the next.
- Sits between the execution units and the seven-segment decoder; drives the same sinal/display interface the decoder already consumes.

---
 rtl/hex_display_arbiter_pkg.sv | 14 +
 rtl/hex_display_arbiter_rr_arbiter.sv | 35 +++
 rtl/hex_display_arbiter.sv | 112 +++++++++++
 tb/tb_hex_display_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hex_display_arbiter_pkg.sv
// Shared definitions for the hex display arbiter: FSM encoding and the
// nibble-packed display field layout consumed by the seven-segment decoder.
package hex_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SHOW = 1'b1
    } state_t;

    localparam int OP1_LSB  = 24;
    localparam int OP2_LSB  = 16;
    localparam int DADO_LSB = 0;

endpackage

// File: rtl/hex_display_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request searching upward from
// rr_ptr_i, wrapping at NREQ.
module rr_arbiter #(
    parameter int NREQ = 3
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [1:0]      rr_ptr_i,
    output logic            grant_valid_o,
    output logic [1:0]      grant_idx_o
);

    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic [2:0]        sum;

    always_comb begin
        grant_valid_o = 1'b0;
        sum           = 3'd0;
        dbl           = {req_i, req_i};
        // Rotating the doubled vector puts rr_ptr at bit 0 so the lowest set
        // bit of rot is the highest-priority requester.
        rot           = NREQ'(dbl >> rr_ptr_i);
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (rot[j]) begin
                grant_valid_o = 1'b1;
                sum           = {1'b0, rr_ptr_i} + 3'(j);
            end
        end
        if (sum >= 3'(NREQ)) begin
            sum = sum - 3'(NREQ);
        end
        grant_idx_o = sum[1:0];
    end

endmodule

// File: rtl/hex_display_arbiter.sv
// Shares one 8-digit hex display among NREQ result producers: round-robin
// grant, one-cycle ack, then the winner's value is held for DWELL cycles.
module hex_display_arbiter
    import hex_pkg::*;
#(
    parameter int NREQ  = 3,
    parameter int DWELL = 50000000,
    parameter int CNT_W = 26
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [16*NREQ-1:0]   req_dado,
    input  logic [8*NREQ-1:0]    req_op1,
    input  logic [8*NREQ-1:0]    req_op2,
    output logic [NREQ-1:0]      ack,
    output logic                 sinal,
    output logic [1:0]           owner,
    output logic                 busy,
    output logic [31:0]          display
);

    state_t            state_q, state_d;
    logic [1:0]        rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic              sinal_q, sinal_d;
    logic              busy_q, busy_d;
    logic [1:0]        owner_q, owner_d;
    logic [31:0]       display_q, display_d;

    logic              grant_valid;
    logic [1:0]        grant_idx;
    int                sel;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req_i         (req),
        .rr_ptr_i      (rr_ptr_q),
        .grant_valid_o (grant_valid),
        .grant_idx_o   (grant_idx)
    );

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        cnt_d     = cnt_q;
        ack_d     = '0;
        sinal_d   = sinal_q;
        busy_d    = busy_q;
        owner_d   = owner_q;
        display_d = display_q;
        sel       = int'(grant_idx);

        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    state_d                     = ST_SHOW;
                    ack_d                       = NREQ'(1) << grant_idx;
                    owner_d                     = grant_idx;
                    display_d[OP1_LSB +: 8]     = req_op1[8*sel +: 8];
                    display_d[OP2_LSB +: 8]     = req_op2[8*sel +: 8];
                    display_d[DADO_LSB +: 16]   = req_dado[16*sel +: 16];
                    sinal_d                     = 1'b1;
                    busy_d                      = 1'b1;
                    cnt_d                       = CNT_W'(DWELL - 1);
                    rr_ptr_d                    = (grant_idx == 2'(NREQ - 1)) ? 2'd0
                                                                              : grant_idx + 2'd1;
                end
            end
            ST_SHOW: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    sinal_d = 1'b0;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Everything, including the displayed value, is cleared by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= 2'd0;
            cnt_q     <= '0;
            ack_q     <= '0;
            sinal_q   <= 1'b0;
            busy_q    <= 1'b0;
            owner_q   <= 2'd0;
            display_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            cnt_q     <= cnt_d;
            ack_q     <= ack_d;
            sinal_q   <= sinal_d;
            busy_q    <= busy_d;
            owner_q   <= owner_d;
            display_q <= display_d;
        end
    end

    assign ack     = ack_q;
    assign sinal   = sinal_q;
    assign busy    = busy_q;
    assign owner   = owner_q;
    assign display = display_q;

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Self-checking bench for hex_display_arbiter (NREQ=3, DWELL=4) against a
// transaction-level model of the grant/dwell rules.
module tb_hex_display_arbiter;

    localparam int NREQ  = 3;
    localparam int DWELL = 4;
    localparam int CNT_W = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req = '0;
    logic [16*NREQ-1:0] req_dado = '0;
    logic [8*NREQ-1:0] req_op1 = '0;
    logic [8*NREQ-1:0] req_op2 = '0;
    logic [NREQ-1:0]   ack;
    logic              sinal;
    logic [1:0]        owner;
    logic              busy;
    logic [31:0]       display;

    int vectors    = 0;
    int miscompares = 0;

    hex_display_arbiter #(.NREQ(NREQ), .DWELL(DWELL), .CNT_W(CNT_W)) dut (
        .clock    (clock),
        .reset    (reset),
        .req      (req),
        .req_dado (req_dado),
        .req_op1  (req_op1),
        .req_op2  (req_op2),
        .ack      (ack),
        .sinal    (sinal),
        .owner    (owner),
        .busy     (busy),
        .display  (display)
    );

    always #5 clock = ~clock;

    // Reference model: remaining display time, next-priority pointer, last shown value.
    int          m_left;
    int          m_ptr;
    logic [2:0]  m_ack;
    logic [1:0]  m_owner;
    logic [31:0] m_disp;

    wire [38:0] dut_out = {ack, sinal, busy, owner, display};

    task automatic model_reset();
        m_left  = 0;
        m_ptr   = 0;
        m_ack   = '0;
        m_owner = '0;
        m_disp  = '0;
    endtask

    task automatic model_edge();
        m_ack = '0;
        if (m_left > 0) begin
            m_left = m_left - 1;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                int w;
                w = (m_ptr + k) % NREQ;
                if (req[w]) begin
                    m_ack[w] = 1'b1;
                    m_owner  = w[1:0];
                    m_disp   = {req_op1[8*w +: 8], req_op2[8*w +: 8], req_dado[16*w +: 16]};
                    m_left   = DWELL;
                    m_ptr    = (w + 1) % NREQ;
                    break;
                end
            end
        end
    endtask

    function automatic logic [38:0] m_out();
        logic s;
        s = (m_left > 0);
        return {m_ack, s, s, m_owner, m_disp};
    endfunction

    task automatic tick();
        @(posedge clock);
        if (!reset) model_edge();
        @(negedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        req   = '0;
        #1;
        model_reset();
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #2 reset = 1'b1;
        #2;
        model_reset();
        vectors++;
        if (dut_out !== 39'h0) begin
            miscompares++;
            $display("FAIL reset_state: got %h expected %h", dut_out, 39'h0);
        end
        @(negedge clock);
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            vectors++;
            if (dut_out !== m_out()) begin
                miscompares++;
                $display("FAIL idle_no_req c%0d: got %h expected %h", c, dut_out, m_out());
            end
        end
    endtask

    task automatic test_single();
        int hi;
        req_dado[31:16] = 16'hBEEF;
        req_op1[15:8]   = 8'h12;
        req_op2[15:8]   = 8'h34;
        req             = 3'b010;
        tick();
        vectors++;
        if (ack !== 3'b010 || display !== 32'h1234BEEF) begin
            miscompares++;
            $display("FAIL single_grant: got ack=%b disp=%h expected ack=010 disp=1234beef", ack, display);
        end
        req = '0;
        hi  = (sinal === 1'b1) ? 1 : 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (sinal === 1'b1) hi++;
            vectors++;
            if (dut_out !== m_out()) begin
                miscompares++;
                $display("FAIL single_dwell c%0d: got %h expected %h", c, dut_out, m_out());
            end
        end
        vectors++;
        if (hi != DWELL) begin
            miscompares++;
            $display("FAIL single_sinal_width: got %0d expected %0d", hi, DWELL);
        end
        vectors++;
        if (display !== 32'h1234BEEF || sinal !== 1'b0) begin
            miscompares++;
            $display("FAIL single_hold: got disp=%h sinal=%b expected 1234beef 0", display, sinal);
        end
    endtask

    task automatic test_round_robin();
        int order[$];
        int when[$];
        int exp_order[4] = '{0, 1, 2, 0};
        logic [2:0] prev_ack;
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            req_dado[16*i +: 16] = 16'(16'h1000 * (i + 1) + 16'h00A5);
            req_op1[8*i +: 8]    = 8'(8'h10 + i);
            req_op2[8*i +: 8]    = 8'(8'h20 + i);
        end
        req      = 3'b111;
        prev_ack = '0;
        for (int c = 0; c < 25; c++) begin
            tick();
            vectors++;
            if (dut_out !== m_out()) begin
                miscompares++;
                $display("FAIL rr_cycle c%0d: got %h expected %h", c, dut_out, m_out());
            end
            if (ack !== 3'b000) begin
                vectors++;
                if (prev_ack !== 3'b000) begin
                    miscompares++;
                    $display("FAIL rr_ack_width c%0d: got prev=%b now=%b expected prev=000", c, prev_ack, ack);
                end
                for (int b = 0; b < NREQ; b++) begin
                    if (ack[b]) begin
                        order.push_back(b);
                        when.push_back(c);
                        req_dado[16*b +: 16] = req_dado[16*b +: 16] + 16'h0111;
                    end
                end
            end
            prev_ack = ack;
        end
        vectors++;
        if (order.size() < 4) begin
            miscompares++;
            $display("FAIL rr_grant_count: got %0d expected >=4", order.size());
        end else begin
            for (int g = 0; g < 4; g++) begin
                vectors++;
                if (order[g] != exp_order[g]) begin
                    miscompares++;
                    $display("FAIL rr_order g%0d: got %0d expected %0d", g, order[g], exp_order[g]);
                end
                if (g > 0) begin
                    vectors++;
                    if (when[g] - when[g-1] != DWELL + 1) begin
                        miscompares++;
                        $display("FAIL rr_spacing g%0d: got %0d expected %0d", g, when[g] - when[g-1], DWELL + 1);
                    end
                end
            end
        end
        req = '0;
    endtask

    task automatic test_late_request();
        int ack_at;
        logic [2:0] ack_seen;
        do_reset();
        req_dado[15:0] = 16'h0A0A;
        req            = 3'b001;
        tick();
        vectors++;
        if (ack !== 3'b001) begin
            miscompares++;
            $display("FAIL late_first_grant: got %b expected 001", ack);
        end
        req = '0;
        tick();
        req_dado[47:32] = 16'hC0DE;
        req_op1[23:16]  = 8'h77;
        req_op2[23:16]  = 8'h88;
        req             = 3'b100;
        ack_at          = -1;
        ack_seen        = '0;
        for (int c = 2; c < 14; c++) begin
            tick();
            vectors++;
            if (dut_out !== m_out()) begin
                miscompares++;
                $display("FAIL late_cycle c%0d: got %h expected %h", c, dut_out, m_out());
            end
            if (ack !== 3'b000 && ack_at < 0) begin
                ack_at   = c;
                ack_seen = ack;
                req      = '0;
            end
        end
        vectors++;
        if (ack_at != DWELL + 1 || ack_seen !== 3'b100) begin
            miscompares++;
            $display("FAIL late_grant: got cycle %0d ack %b expected cycle %0d ack 100", ack_at, ack_seen, DWELL + 1);
        end
    endtask

    task automatic test_withdrawn();
        logic [31:0] saved;
        logic        seen;
        do_reset();
        req_dado[31:16] = 16'h5151;
        req             = 3'b010;
        tick();
        req = '0;
        tick();
        saved          = display;
        req_dado[15:0] = 16'hDEAD;
        req            = 3'b001;
        tick();
        req  = '0;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (ack !== 3'b000) seen = 1'b1;
            vectors++;
            if (dut_out !== m_out()) begin
                miscompares++;
                $display("FAIL withdrawn_cycle c%0d: got %h expected %h", c, dut_out, m_out());
            end
        end
        vectors++;
        if (seen !== 1'b0 || display !== saved) begin
            miscompares++;
            $display("FAIL withdrawn: got acked=%b disp=%h expected 0 %h", seen, display, saved);
        end
    endtask

    task automatic test_reset_mid_show();
        do_reset();
        for (int i = 0; i < NREQ; i++) req_dado[16*i +: 16] = 16'(16'hE000 + i);
        req = 3'b111;
        tick();
        tick();
        vectors++;
        if (sinal !== 1'b1 || display === 32'h0) begin
            miscompares++;
            $display("FAIL midshow_setup: got sinal=%b disp=%h expected showing", sinal, display);
        end
        reset = 1'b1;
        #1;
        model_reset();
        vectors++;
        if (display !== 32'h0 || sinal !== 1'b0 || busy !== 1'b0 || ack !== 3'b000) begin
            miscompares++;
            $display("FAIL midshow_reset: got disp=%h sinal=%b busy=%b ack=%b expected all zero",
                     display, sinal, busy, ack);
        end
        @(negedge clock);
        reset = 1'b0;
        tick();
        vectors++;
        if (ack !== 3'b001 || dut_out !== m_out()) begin
            miscompares++;
            $display("FAIL midshow_regrant: got %h expected %h", dut_out, m_out());
        end
        req = '0;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req[i] && m_ack[i]) begin
                    if ($urandom_range(1, 0) == 0) req[i] = 1'b0;
                    else req_dado[16*i +: 16] = 16'($urandom);
                end else if (!req[i]) begin
                    if ($urandom_range(3, 0) == 0) begin
                        req[i]               = 1'b1;
                        req_dado[16*i +: 16] = 16'($urandom);
                        req_op1[8*i +: 8]    = 8'($urandom);
                        req_op2[8*i +: 8]    = 8'($urandom);
                    end
                end else if ($urandom_range(15, 0) == 0) begin
                    req[i] = 1'b0;
                end
            end
            tick();
            vectors++;
            if (dut_out !== m_out()) begin
                miscompares++;
                $display("FAIL random c%0d: got %h expected %h", c, dut_out, m_out());
            end
        end
        req = '0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_late_request();
        test_withdrawn();
        test_reset_mid_show();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
